// File: rtl/song_timer.sv
// Song clock for the rhythm game: counts beats while the game mode is RUN,
// freezes on PAUSE, and flags song completion with a one-cycle fin_check pulse.
module song_timer #(
    parameter int TICK_DIV   = 100000,
    parameter int SONG_BEATS = 64,
    parameter int BEAT_W     = $clog2(SONG_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode,
    input  logic [1:0]        diff,
    output logic              fin_check,
    output logic              beat_tick,
    output logic [BEAT_W-1:0] beat_count,
    output logic              running
);

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [2:0] M_RUN    = 3'd4;
    localparam logic [2:0] M_PAUSE  = 3'd5;
    localparam logic [2:0] M_FINISH = 3'd6;

    typedef enum logic [1:0] {
        S_STOP,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_presc, w_presc_nxt;
    logic [1:0]        r_diff, w_diff_nxt;
    logic [BEAT_W-1:0] r_beat_count, w_beat_count_nxt;
    logic              r_beat_tick, w_beat_tick_nxt;
    logic              r_fin_check, w_fin_check_nxt;
    logic [PW-1:0]     w_last;
    logic              w_mode_clear;

    // Terminal prescaler value for the latched difficulty (period-1).
    always_comb begin
        case (r_diff)
            2'd0:    w_last = PW'(TICK_DIV - 1);
            2'd1:    w_last = PW'((TICK_DIV >> 1) - 1);
            default: w_last = PW'((TICK_DIV >> 2) - 1);
        endcase
    end

    assign w_mode_clear = (mode != M_RUN) && (mode != M_PAUSE) && (mode != M_FINISH);

    always_comb begin
        w_state_nxt      = r_state;
        w_presc_nxt      = r_presc;
        w_diff_nxt       = r_diff;
        w_beat_count_nxt = r_beat_count;
        w_beat_tick_nxt  = 1'b0;
        w_fin_check_nxt  = 1'b0;

        case (r_state)
            S_STOP: begin
                w_presc_nxt      = '0;
                w_beat_count_nxt = '0;
                if (mode == M_RUN) begin
                    w_state_nxt = S_RUN;
                    w_diff_nxt  = (diff == 2'd3) ? 2'd2 : diff;
                end
            end
            // A HOLD edge with mode RUN counts exactly like a RUN edge, so a
            // tick deferred by a pause fires on the resume edge.
            S_RUN, S_HOLD: begin
                if (mode == M_RUN) begin
                    w_state_nxt = S_RUN;
                    if (r_presc == w_last) begin
                        w_presc_nxt      = '0;
                        w_beat_count_nxt = r_beat_count + BEAT_W'(1);
                        w_beat_tick_nxt  = 1'b1;
                        if (r_beat_count == BEAT_W'(SONG_BEATS - 1)) begin
                            w_fin_check_nxt = 1'b1;
                            w_state_nxt     = S_DONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end else if (mode == M_PAUSE) begin
                    w_state_nxt = S_HOLD;
                end else if (mode == M_FINISH) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt      = S_STOP;
                    w_presc_nxt      = '0;
                    w_beat_count_nxt = '0;
                end
            end
            S_DONE: begin
                if (w_mode_clear) begin
                    w_state_nxt      = S_STOP;
                    w_presc_nxt      = '0;
                    w_beat_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt      = S_STOP;
                w_presc_nxt      = '0;
                w_beat_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_STOP;
            r_presc      <= '0;
            r_diff       <= '0;
            r_beat_count <= '0;
            r_beat_tick  <= 1'b0;
            r_fin_check  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_diff       <= w_diff_nxt;
            r_beat_count <= w_beat_count_nxt;
            r_beat_tick  <= w_beat_tick_nxt;
            r_fin_check  <= w_fin_check_nxt;
        end
    end

    assign fin_check  = r_fin_check;
    assign beat_tick  = r_beat_tick;
    assign beat_count = r_beat_count;
    assign running    = (r_state == S_RUN);

endmodule
